bumpy_ball_move: RTL and testbench

Frame-rate motion controller for the player sprite, replacing the single-axis gravity mover. It tracks X and Y in signed fixed point and runs a GROUND / RISING / FALLING state machine with edge-triggered jumps. Collision edges reported by the pixel-rate hit detector are accumulated over each frame and resolved once per frame. It feeds `topLeftX`/`topLeftY` to the sprite drawer and sits between the hit detector and the bitmap mux.

---
 rtl/bumpy_ball_move.sv | 179 +++++++++++++++++
 tb/tb_bumpy_ball_move.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bumpy_ball_move.sv
`default_nettype none
// ==========================================================================
// bumpy_ball_move : frame-rate X/Y sprite mover with GROUND/RISING/FALLING
// Optional macro HORIZONTAL_WRAP_EN : X wraps around instead of clamping.
// Rev 1.0
// ==========================================================================
module bumpy_ball_move #(
  parameter int INITIAL_X      = 100,
  parameter int INITIAL_Y      = 100,
  parameter int FRAC_BITS      = 6,
  parameter int POS_W          = 11,
  parameter int SPEED_W        = 16,
  parameter int SIDE_SPEED     = 128,
  parameter int JUMP_SPEED     = 400,
  parameter int GRAVITY        = 10,
  parameter int MAX_FALL_SPEED = 640,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int OBJ_W          = 32,
  parameter int OBJ_H          = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    right,
  input  logic                    left,
  input  logic                    jump,
  input  logic                    collision,
  input  logic [3:0]              HitEdgeCode,
  output logic signed [POS_W-1:0] topLeftX,
  output logic signed [POS_W-1:0] topLeftY,
  output logic [1:0]              moveState
);

  localparam int PW = POS_W + FRAC_BITS + 1;
  localparam int SW = SPEED_W;
  localparam int CW = ((PW > SW) ? PW : SW) + 1;

  localparam logic signed [PW-1:0] c_X_INIT = PW'(INITIAL_X << FRAC_BITS);
  localparam logic signed [PW-1:0] c_Y_INIT = PW'(INITIAL_Y << FRAC_BITS);
  localparam logic signed [CW-1:0] c_X_LIM  = CW'((X_MAX + 1 - OBJ_W) << FRAC_BITS);
  localparam logic signed [CW-1:0] c_Y_LIM  = CW'((Y_MAX + 1 - OBJ_H) << FRAC_BITS);
  localparam logic signed [SW-1:0] c_SIDE   = SW'(SIDE_SPEED);
  localparam logic signed [SW-1:0] c_JUMP   = SW'(JUMP_SPEED);
  localparam logic signed [SW-1:0] c_GRAV   = SW'(GRAVITY);
  localparam logic signed [SW-1:0] c_MAXF   = SW'(MAX_FALL_SPEED);
  localparam logic signed [SW:0]   c_SAT_HI = (SW+1)'(2**(SW-1) - 1);
  localparam logic signed [SW:0]   c_SAT_LO = (SW+1)'(-(2**(SW-1)));

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } state_t;

  state_t                r_state, w_state;
  logic signed [PW-1:0]  r_posX, r_posY, w_posX, w_posY;
  logic signed [SW-1:0]  r_ySpeed, w_ySpeed, w_xSpeed;
  logic signed [CW-1:0]  w_xSum, w_ySum;
  logic [3:0]            r_hitLatch;
  logic                  r_jumpPend, r_jumpPrev;
  logic                  w_jumpEdge;

  function automatic logic signed [SW-1:0] sat_add(input logic signed [SW-1:0] a,
                                                   input logic signed [SW-1:0] b);
    logic signed [SW:0] s;
    s = {a[SW-1], a} + {b[SW-1], b};
    if (s > c_SAT_HI)      sat_add = c_SAT_HI[SW-1:0];
    else if (s < c_SAT_LO) sat_add = c_SAT_LO[SW-1:0];
    else                   sat_add = s[SW-1:0];
  endfunction

  assign w_jumpEdge = jump & ~r_jumpPrev;

  // Events seen on the frame cycle itself belong to the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hitLatch <= '0;
      r_jumpPend <= 1'b0;
      r_jumpPrev <= 1'b0;
    end else begin
      r_jumpPrev <= jump;
      if (startOfFrame) begin
        r_hitLatch <= collision ? HitEdgeCode : 4'b0000;
        r_jumpPend <= w_jumpEdge;
      end else begin
        if (collision)  r_hitLatch <= r_hitLatch | HitEdgeCode;
        if (w_jumpEdge) r_jumpPend <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state  = r_state;
    w_ySpeed = r_ySpeed;
    w_xSpeed = '0;
    if (right && !left)      w_xSpeed = c_SIDE;
    else if (left && !right) w_xSpeed = -c_SIDE;
    if (r_hitLatch[3] && w_xSpeed[SW-1])                       w_xSpeed = '0;
    if (r_hitLatch[1] && !w_xSpeed[SW-1] && (w_xSpeed != '0)) w_xSpeed = '0;

    case (r_state)
      GROUND: begin
        if (r_jumpPend) begin
          w_ySpeed = -c_JUMP;
          w_state  = RISING;
        end else if (!r_hitLatch[0]) begin
          w_ySpeed = c_GRAV;
          w_state  = FALLING;
        end else begin
          w_ySpeed = '0;
        end
      end
      RISING: begin
        if (r_hitLatch[2]) begin
          w_ySpeed = '0;
          w_state  = FALLING;
        end else begin
          w_ySpeed = sat_add(r_ySpeed, c_GRAV);
          if (!w_ySpeed[SW-1]) w_state = FALLING;
        end
      end
      FALLING: begin
        if (r_hitLatch[0] && !r_ySpeed[SW-1]) begin
          w_ySpeed = '0;
          w_state  = GROUND;
        end else begin
          w_ySpeed = sat_add(r_ySpeed, c_GRAV);
          if (w_ySpeed > c_MAXF) w_ySpeed = c_MAXF;
        end
      end
      default: w_state = FALLING;
    endcase

    w_ySum = {{(CW-PW){r_posY[PW-1]}}, r_posY} + {{(CW-SW){w_ySpeed[SW-1]}}, w_ySpeed};
    w_xSum = {{(CW-PW){r_posX[PW-1]}}, r_posX} + {{(CW-SW){w_xSpeed[SW-1]}}, w_xSpeed};
    w_posY = w_ySum[PW-1:0];
    w_posX = w_xSum[PW-1:0];

    if (w_ySum > c_Y_LIM) begin
      w_posY   = c_Y_LIM[PW-1:0];
      w_ySpeed = '0;
      w_state  = GROUND;
    end else if (w_ySum[CW-1]) begin
      w_posY   = '0;
      w_ySpeed = '0;
      w_state  = FALLING;
    end

    // X speed is rebuilt from the levels every frame, so only position is bounded.
`ifdef HORIZONTAL_WRAP_EN
    if (w_xSum[CW-1])          w_posX = c_X_LIM[PW-1:0];
    else if (w_xSum > c_X_LIM) w_posX = '0;
`else
    if (w_xSum[CW-1])          w_posX = '0;
    else if (w_xSum > c_X_LIM) w_posX = c_X_LIM[PW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FALLING;
      r_posX   <= c_X_INIT;
      r_posY   <= c_Y_INIT;
      r_ySpeed <= '0;
    end else if (startOfFrame) begin
      r_state  <= w_state;
      r_posX   <= w_posX;
      r_posY   <= w_posY;
      r_ySpeed <= w_ySpeed;
    end
  end

  assign topLeftX  = r_posX[FRAC_BITS +: POS_W];
  assign topLeftY  = r_posY[FRAC_BITS +: POS_W];
  assign moveState = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bumpy_ball_move.sv
`default_nettype none
// ==========================================================================
// tb_bumpy_ball_move : directed frame-by-frame vectors for bumpy_ball_move
// Rev 1.0
// ==========================================================================
module tb_bumpy_ball_move;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               right = 1'b0;
  logic               left = 1'b0;
  logic               jump = 1'b0;
  logic               collision = 1'b0;
  logic [3:0]         HitEdgeCode = 4'd0;
  logic signed [10:0] topLeftX, topLeftY;
  logic [1:0]         moveState;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         n;
    bit         r, l, j, c;
    logic [3:0] code;
    int         ex, ey, es;
  } vec_t;

  vec_t vq[$];

  bumpy_ball_move dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .right        (right),
    .left         (left),
    .jump         (jump),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .moveState    (moveState)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic add(input int n, input int r, input int l, input int j, input int c,
                     input int code, input int ex, input int ey, input int es);
    vec_t v;
    v.n = n; v.r = (r != 0); v.l = (l != 0); v.j = (j != 0); v.c = (c != 0);
    v.code = 4'(code); v.ex = ex; v.ey = ey; v.es = es;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ex, input int ey, input int es);
    chk({tag, " X"}, int'(topLeftX), ex);
    chk({tag, " Y"}, int'(topLeftY), ey);
    chk({tag, " state"}, int'(moveState), es);
  endtask

  // One frame body: levels, optional jump edge, optional collision pulse.
  task automatic frame_body(input bit r, input bit l, input bit j, input bit c,
                            input logic [3:0] code);
    @(negedge clk); right = r; left = l; jump = j;
    @(negedge clk); jump = 1'b0; collision = c; HitEdgeCode = c ? code : 4'd0;
    @(negedge clk); collision = 1'b0; HitEdgeCode = 4'd0;
    @(negedge clk);
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  initial begin
    int px, py, ps;

    // n, r, l, j, c, code, X, Y, state
    add(  7, 0,0,0,0, 4'h0, 100, 104, 2);  // free fall
    add( 13, 0,0,0,0, 4'h0, 100, 132, 2);
    add(  1, 0,0,0,1, 4'h1, 100, 132, 0);  // land
    add(  3, 0,0,0,1, 4'h1, 100, 132, 0);  // resting contact
    add(  1, 0,0,1,1, 4'h1, 100, 126, 1);  // jump
    add( 38, 0,0,0,0, 4'h0, 100,   4, 1);
    add(  1, 0,0,0,0, 4'h0, 100,   4, 1);
    add(  1, 0,0,0,0, 4'h0, 100,   4, 2);  // 40th frame after jump
    add(  1, 0,0,0,0, 4'h0, 100,   4, 2);
    add(  1, 0,0,0,1, 4'h1, 100,   4, 0);
    add( 10, 1,0,0,1, 4'h1, 120,   4, 0);  // walk right
    add(  3, 1,1,0,1, 4'h1, 120,   4, 0);  // both held
    add(  2, 0,1,0,1, 4'h1, 116,   4, 0);  // walk left
    add(  4, 1,0,0,1, 4'h3, 116,   4, 0);  // right edge blocks
    add(  2, 0,1,0,1, 4'h9, 116,   4, 0);  // left edge blocks
    add(  1, 0,0,1,1, 4'h1, 116,   0, 2);  // ceiling clamp
    add( 20, 0,0,0,0, 4'h0, 116,  32, 2);
    add(  1, 0,0,0,1, 4'h1, 116,  32, 0);
    add(  1, 0,0,1,1, 4'h1, 116,  26, 1);
    add(  1, 0,0,0,1, 4'h4, 116,  26, 2);  // head hit
    add(  1, 0,0,0,0, 4'h0, 116,  26, 2);
    add(  1, 0,0,0,1, 4'h1, 116,  26, 0);
    add(  1, 0,0,0,0, 4'h0, 116,  26, 2);  // walked off ledge
    add(  1, 0,0,0,0, 4'h0, 116,  27, 2);
    add( 60, 0,0,0,0, 4'h0, 116, 331, 2);
    add(  1, 0,0,0,0, 4'h0, 116, 341, 2);
    add(  1, 0,0,0,0, 4'h0, 116, 351, 2);
    add(  1, 0,0,0,0, 4'h0, 116, 361, 2);  // fall speed capped
    add(  8, 0,0,0,0, 4'h0, 116, 441, 2);
    add(  1, 0,0,0,0, 4'h0, 116, 448, 0);  // floor clamp
    add(  2, 0,0,0,0, 4'h0, 116, 448, 0);
    add(242, 1,0,0,0, 4'h0, 600, 448, 0);
    add(  4, 1,0,0,0, 4'h0, 608, 448, 0);
`ifdef HORIZONTAL_WRAP_EN
    add(  1, 1,0,0,0, 4'h0,   0, 448, 0);
    add(  2, 1,0,0,0, 4'h0,   4, 448, 0);
`else
    add(  1, 1,0,0,0, 4'h0, 608, 448, 0);
    add(  2, 1,0,0,0, 4'h0, 608, 448, 0);
`endif

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_out("reset", 100, 100, 2);
    px = 100; py = 100; ps = 2;

    for (int i = 0; i < vq.size(); i++) begin
      for (int k = 0; k < vq[i].n; k++) begin
        frame_body(vq[i].r, vq[i].l, vq[i].j, vq[i].c, vq[i].code);
        if (k == 0) chk_out($sformatf("row%0d hold", i), px, py, ps);
        sof();
      end
      chk_out($sformatf("row%0d", i), vq[i].ex, vq[i].ey, vq[i].es);
      px = vq[i].ex; py = vq[i].ey; ps = vq[i].es;
    end

    // Reset mid-frame discards a pending jump and a latched bottom hit.
    @(negedge clk); right = 1'b0; left = 1'b0; jump = 1'b1;
    @(negedge clk); jump = 1'b0; collision = 1'b1; HitEdgeCode = 4'h1;
    @(negedge clk); collision = 1'b0; HitEdgeCode = 4'h0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk_out("midreset", 100, 100, 2);
    frame_body(0, 0, 0, 0, 4'h0);
    sof();
    chk_out("midreset frame", 100, 100, 2);

    // Collision on the frame cycle itself lands one frame later.
    @(negedge clk); collision = 1'b1; HitEdgeCode = 4'h1; startOfFrame = 1'b1;
    @(negedge clk); collision = 1'b0; HitEdgeCode = 4'h0; startOfFrame = 1'b0;
    chk_out("sofhit same", 100, 100, 2);
    frame_body(0, 0, 0, 0, 4'h0);
    sof();
    chk_out("sofhit next", 100, 100, 0);

    // Three back-to-back frame pulses are three updates.
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); startOfFrame = 1'b0;
    chk_out("b2b sof", 100, 101, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
